// File: rtl/fd_pipe_reg.sv
// Fetch/Decode pipeline register: captures PC/instruction/AdEL state; all outputs registered, 1-cycle F->D.
// stall holds every D register; req flushes to a handler-PC bubble; rst > req > stall > load.
module fd_pipe_reg #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
    parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        stall,
    input  logic [31:0] F_pc,
    input  logic [31:0] F_instr,
    input  logic        F_exc_adel,
    input  logic        D_is_jump,
    input  logic        D_eret,
    output logic [31:0] D_pc,
    output logic [31:0] D_instr,
    output logic [4:0]  D_exccode,
    output logic        D_bd,
    output logic        D_valid
);

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [4:0]  r_exccode;
    logic        r_bd;
    logic        r_valid;

    // eret has no delay slot, so the instruction following it is never BD
    logic        w_next_bd;
    assign w_next_bd = D_is_jump & ~D_eret;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_instr   <= NOP_INSTR;
            r_exccode <= 5'd0;
            r_bd      <= 1'b0;
            r_valid   <= 1'b0;
        end else if (req) begin
            // Bubble keeps the handler address so CP0 sees a sensible macro-PC
            r_pc      <= HANDLER_PC;
            r_instr   <= NOP_INSTR;
            r_exccode <= 5'd0;
            r_bd      <= 1'b0;
            r_valid   <= 1'b0;
        end else if (!stall) begin
            r_pc    <= F_pc;
            r_bd    <= w_next_bd;
            r_valid <= 1'b1;
            if (F_exc_adel) begin
                // Faulting address stays in r_pc for EPC/BadVAddr
                r_instr   <= NOP_INSTR;
                r_exccode <= EXC_ADEL;
            end else begin
                r_instr   <= F_instr;
                r_exccode <= 5'd0;
            end
        end
    end

    assign D_pc      = r_pc;
    assign D_instr   = r_instr;
    assign D_exccode = r_exccode;
    assign D_bd      = r_bd;
    assign D_valid   = r_valid;

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Bench for fd_pipe_reg: table of {inputs, expected D} records plus a hand-written stall sequence,
// expectations queued at drive time and popped after the capturing edge.
module tb_fd_pipe_reg;

    logic        clk;
    logic        rst;
    logic        req;
    logic        stall;
    logic [31:0] F_pc;
    logic [31:0] F_instr;
    logic        F_exc_adel;
    logic        D_is_jump;
    logic        D_eret;
    logic [31:0] D_pc;
    logic [31:0] D_instr;
    logic [4:0]  D_exccode;
    logic        D_bd;
    logic        D_valid;

    fd_pipe_reg dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .stall      (stall),
        .F_pc       (F_pc),
        .F_instr    (F_instr),
        .F_exc_adel (F_exc_adel),
        .D_is_jump  (D_is_jump),
        .D_eret     (D_eret),
        .D_pc       (D_pc),
        .D_instr    (D_instr),
        .D_exccode  (D_exccode),
        .D_bd       (D_bd),
        .D_valid    (D_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        req;
        logic        stall;
        logic [31:0] fpc;
        logic [31:0] finstr;
        logic        adel;
        logic        jmp;
        logic        eret;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [4:0]  eexc;
        logic        ebd;
        logic        evld;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [4:0]  eexc;
        logic        ebd;
        logic        evld;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(string name, logic r, logic q, logic s,
                                logic [31:0] fpc, logic [31:0] fi, logic adel,
                                logic j, logic er, logic [31:0] epc,
                                logic [31:0] ei, logic [4:0] ee, logic ebd, logic ev);
        vec_t v;
        v.name = name; v.rst = r; v.req = q; v.stall = s;
        v.fpc = fpc; v.finstr = fi; v.adel = adel; v.jmp = j; v.eret = er;
        v.epc = epc; v.einstr = ei; v.eexc = ee; v.ebd = ebd; v.evld = ev;
        return v;
    endfunction

    task automatic check(string name, string field, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h", name, field, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the capturing edge
    task automatic apply(vec_t v);
        exp_t e;
        exp_t got;
        rst = v.rst; req = v.req; stall = v.stall;
        F_pc = v.fpc; F_instr = v.finstr; F_exc_adel = v.adel;
        D_is_jump = v.jmp; D_eret = v.eret;
        e.name = v.name; e.epc = v.epc; e.einstr = v.einstr;
        e.eexc = v.eexc; e.ebd = v.ebd; e.evld = v.evld;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", v.name);
        end else begin
            got = sb.pop_front();
            check(got.name, "D_pc",      D_pc,             got.epc);
            check(got.name, "D_instr",   D_instr,          got.einstr);
            check(got.name, "D_exccode", {27'd0, D_exccode}, {27'd0, got.eexc});
            check(got.name, "D_bd",      {31'd0, D_bd},      {31'd0, got.ebd});
            check(got.name, "D_valid",   {31'd0, D_valid},   {31'd0, got.evld});
        end
    endtask

    initial begin
        //                 name         rst req stl  F_pc          F_instr       adel jmp eret  D_pc          D_instr       exc bd vld
        vecs.push_back(mk("rst0",        1, 0, 0, 32'h3004, 32'h24080001, 0, 0, 0, 32'h3000, 32'h0,        0, 0, 0));
        vecs.push_back(mk("rst1",        1, 0, 0, 32'h3004, 32'h24080001, 0, 0, 0, 32'h3000, 32'h0,        0, 0, 0));
        vecs.push_back(mk("first_load",  0, 0, 0, 32'h3004, 32'h24080001, 0, 0, 0, 32'h3004, 32'h24080001, 0, 0, 1));
        vecs.push_back(mk("load_3008",   0, 0, 0, 32'h3008, 32'h01095020, 0, 0, 0, 32'h3008, 32'h01095020, 0, 0, 1));
        vecs.push_back(mk("stall_a",     0, 0, 1, 32'h300C, 32'hAAAA0001, 0, 1, 0, 32'h3008, 32'h01095020, 0, 0, 1));
        vecs.push_back(mk("stall_b",     0, 0, 1, 32'h3010, 32'hAAAA0002, 1, 1, 0, 32'h3008, 32'h01095020, 0, 0, 1));
        vecs.push_back(mk("stall_c",     0, 0, 1, 32'h3014, 32'hAAAA0003, 0, 0, 0, 32'h3008, 32'h01095020, 0, 0, 1));
        vecs.push_back(mk("release",     0, 0, 0, 32'h300C, 32'h12345678, 0, 0, 0, 32'h300C, 32'h12345678, 0, 0, 1));
        vecs.push_back(mk("bd_set",      0, 0, 0, 32'h3010, 32'h00000021, 0, 1, 0, 32'h3010, 32'h00000021, 0, 1, 1));
        vecs.push_back(mk("bd_clr",      0, 0, 0, 32'h3014, 32'h00000022, 0, 0, 0, 32'h3014, 32'h00000022, 0, 0, 1));
        vecs.push_back(mk("eret_no_bd",  0, 0, 0, 32'h3018, 32'h00000023, 0, 1, 1, 32'h3018, 32'h00000023, 0, 0, 1));
        vecs.push_back(mk("adel",        0, 0, 0, 32'h3002, 32'hFFFFFFFF, 1, 0, 0, 32'h3002, 32'h0,        4, 0, 1));
        vecs.push_back(mk("flush_stall", 0, 1, 1, 32'h3020, 32'h55555555, 0, 1, 0, 32'h4180, 32'h0,        0, 0, 0));
        vecs.push_back(mk("load_3030",   0, 0, 0, 32'h3030, 32'h11111111, 0, 1, 0, 32'h3030, 32'h11111111, 0, 1, 1));
        vecs.push_back(mk("stall_3030",  0, 0, 1, 32'h3034, 32'h22222222, 0, 0, 0, 32'h3030, 32'h11111111, 0, 1, 1));
        vecs.push_back(mk("rst_in_stall",1, 0, 1, 32'h3034, 32'h22222222, 0, 1, 0, 32'h3000, 32'h0,        0, 0, 0));
        vecs.push_back(mk("stall_post",  0, 0, 1, 32'h3034, 32'h22222222, 0, 1, 0, 32'h3000, 32'h0,        0, 0, 0));
        vecs.push_back(mk("resume",      0, 0, 0, 32'h3034, 32'h22222222, 0, 0, 0, 32'h3034, 32'h22222222, 0, 0, 1));
        vecs.push_back(mk("flush_adel",  0, 1, 0, 32'h3038, 32'hFFFFFFFF, 1, 0, 0, 32'h4180, 32'h0,        0, 0, 0));
        vecs.push_back(mk("rst_over_req",1, 1, 0, 32'h3038, 32'h33333333, 0, 0, 0, 32'h3000, 32'h0,        0, 0, 0));
        vecs.push_back(mk("jmp_1",       0, 0, 0, 32'h303C, 32'h10000001, 0, 1, 0, 32'h303C, 32'h10000001, 0, 1, 1));
        vecs.push_back(mk("jmp_2",       0, 0, 0, 32'h3040, 32'h10000002, 0, 1, 0, 32'h3040, 32'h10000002, 0, 1, 1));
        vecs.push_back(mk("stall_bd",    0, 0, 1, 32'h3044, 32'h10000003, 0, 0, 0, 32'h3040, 32'h10000002, 0, 1, 1));
        vecs.push_back(mk("adel_2",      0, 0, 0, 32'h7000, 32'h44444444, 1, 0, 0, 32'h7000, 32'h0,        4, 0, 1));
        vecs.push_back(mk("stall_exc",   0, 0, 1, 32'h3048, 32'h55550000, 0, 1, 0, 32'h7000, 32'h0,        4, 0, 1));
        vecs.push_back(mk("exc_clear",   0, 0, 0, 32'h3048, 32'h55550000, 0, 0, 0, 32'h3048, 32'h55550000, 0, 0, 1));

        foreach (vecs[i]) apply(vecs[i]);

        // Long stall with random fetch data: D must hold the last load, including BD
        apply(mk("seq_load", 0, 0, 0, 32'h3100, 32'hCAFEF00D, 0, 1, 0, 32'h3100, 32'hCAFEF00D, 0, 1, 1));
        for (int k = 0; k < 6; k++) begin
            apply(mk("seq_hold", 0, 0, 1, {20'h0, 4'h3, $urandom_range(0, 255) << 2},
                     $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
                     32'h3100, 32'hCAFEF00D, 0, 1, 1));
        end
        apply(mk("seq_release", 0, 0, 0, 32'h3104, 32'h0BADBEEF, 0, 0, 0, 32'h3104, 32'h0BADBEEF, 0, 0, 1));
        apply(mk("seq_flush",   0, 1, 0, 32'h3108, 32'h0BADBEE1, 0, 1, 0, 32'h4180, 32'h0,        0, 0, 0));
        apply(mk("seq_after",   0, 0, 0, 32'h4180, 32'h40806000, 0, 0, 0, 32'h4180, 32'h40806000, 0, 0, 1));

        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
